rx_byte_framer: RTL and testbench

- Serial-to-parallel receive framer for the USB RX path. Sits between the NRZI decoder / bit-unstuffer (source of shift_strobe, serial_in) and the RX packet controller.
- Hunts for a programmable SYNC pattern in the incoming bit stream, then assembles DATA_W-bit bytes and flags each one with a single-cycle valid strobe.
- Reports truncated bytes at end-of-packet and keeps a saturating per-packet byte count.

---
 rtl/rx_byte_framer_pkg.sv | 24 ++
 rtl/rx_byte_framer_if.sv | 34 +++
 rtl/rx_byte_framer_stp_sr.sv | 49 ++++
 rtl/rx_byte_framer.sv | 130 +++++++++++++
 tb/tb_rx_byte_framer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rx_byte_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_framer_pkg
// Brief    : Shared types and defaults for the USB RX byte framer.
// Revision : 1.0
// ============================================================================
package rx_framer_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [7:0] USB_SYNC_RX = 8'h80;
  localparam int         DATA_W_DEF  = 8;
  localparam int         CNT_W_DEF   = 7;

  // Width of the in-byte bit counter; never narrower than one bit.
  function automatic int bit_cnt_width(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_byte_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_byte_framer_if
// Brief    : Bit-stream input and byte output bundle of the RX byte framer.
// Revision : 1.0
// ============================================================================
interface rx_byte_framer_if import rx_framer_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              shift_strobe;
  logic              serial_in;
  logic              eop;
  logic              clear;
  logic [DATA_W-1:0] rx_data;
  logic              byte_valid;
  logic              sync_detected;
  logic              in_packet;
  logic              byte_err;
  logic [CNT_W-1:0]  byte_count;

  modport master (
    output shift_strobe, serial_in, eop, clear,
    input  rx_data, byte_valid, sync_detected, in_packet, byte_err, byte_count
  );

  modport slave (
    input  shift_strobe, serial_in, eop, clear,
    output rx_data, byte_valid, sync_detected, in_packet, byte_err, byte_count
  );

endinterface
`default_nettype wire

// File: rtl/rx_byte_framer_stp_sr.sv
`default_nettype none
// ============================================================================
// Module   : flex_stp_sr
// Brief    : Serial-to-parallel shift register with synchronous clear.
// Revision : 1.0
// ============================================================================
module flex_stp_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b0
) (
  input  wire logic                clk,
  input  wire logic                n_rst,
  input  wire logic                shift_enable,
  input  wire logic                sync_clear,
  input  wire logic                serial_in,
  output logic      [NUM_BITS-1:0] next_out
);

  logic [NUM_BITS-1:0] sr_q;
  logic [NUM_BITS-1:0] sr_d;

  // next_out is the post-shift view so callers can act in the strobe cycle.
  generate
    if (SHIFT_MSB) begin : g_shift_msb
      assign next_out = {sr_q[NUM_BITS-2:0], serial_in};
    end else begin : g_shift_lsb
      assign next_out = {serial_in, sr_q[NUM_BITS-1:1]};
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (sync_clear) begin
      sr_d = '0;
    end else if (shift_enable) begin
      sr_d = next_out;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_byte_framer.sv
`default_nettype none
// ============================================================================
// Module   : rx_byte_framer
// Brief    : Hunts for SYNC, then frames DATA_W-bit bytes from the RX stream.
// Revision : 1.0
// ============================================================================
module rx_byte_framer import rx_framer_pkg::*; #(
  parameter int                DATA_W       = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = DATA_W'(USB_SYNC_RX),
  parameter bit                LSB_FIRST    = 1'b1,
  parameter int                CNT_W        = CNT_W_DEF
) (
  input wire logic        clk,
  input wire logic        n_rst,
  rx_byte_framer_if.slave bus
);

  localparam int                     BIT_CNT_W = bit_cnt_width(DATA_W);
  localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]       COUNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic [CNT_W-1:0]       byte_count_q, byte_count_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   sync_detected_q, sync_detected_d;
  logic                   byte_err_q, byte_err_d;
  logic                   in_packet_q, in_packet_d;

  logic                   sr_shift;
  logic                   sr_clear;
  logic [DATA_W-1:0]      sr_next;

  flex_stp_sr #(
    .NUM_BITS  (DATA_W),
    .SHIFT_MSB (!LSB_FIRST)
  ) u_shift_core (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (sr_shift),
    .sync_clear   (sr_clear),
    .serial_in    (bus.serial_in),
    .next_out     (sr_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= HUNT;
      bit_cnt_q       <= '0;
      rx_data_q       <= '0;
      byte_count_q    <= '0;
      byte_valid_q    <= 1'b0;
      sync_detected_q <= 1'b0;
      byte_err_q      <= 1'b0;
      in_packet_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_data_q       <= rx_data_d;
      byte_count_q    <= byte_count_d;
      byte_valid_q    <= byte_valid_d;
      sync_detected_q <= sync_detected_d;
      byte_err_q      <= byte_err_d;
      in_packet_q     <= in_packet_d;
    end
  end

  // Priority: clear, then eop (DATA only), then the strobe; a dropped bit never shifts.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    rx_data_d       = rx_data_q;
    byte_count_d    = byte_count_q;
    byte_valid_d    = 1'b0;
    sync_detected_d = 1'b0;
    byte_err_d      = 1'b0;
    sr_shift        = 1'b0;
    sr_clear        = 1'b0;

    if (bus.clear) begin
      state_d   = HUNT;
      bit_cnt_d = '0;
      sr_clear  = 1'b1;
    end else if ((state_q == DATA) && bus.eop) begin
      state_d    = HUNT;
      bit_cnt_d  = '0;
      sr_clear   = 1'b1;
      byte_err_d = (bit_cnt_q != '0);
    end else if (bus.shift_strobe) begin
      sr_shift = 1'b1;
      case (state_q)
        HUNT: begin
          if (sr_next == SYNC_PATTERN) begin
            state_d         = DATA;
            bit_cnt_d       = '0;
            byte_count_d    = '0;
            sync_detected_d = 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d    = '0;
            rx_data_d    = sr_next;
            byte_valid_d = 1'b1;
            if (byte_count_q != COUNT_MAX) begin
              byte_count_d = byte_count_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    in_packet_d = (state_d == DATA);
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.byte_valid    = byte_valid_q;
  assign bus.sync_detected = sync_detected_q;
  assign bus.in_packet     = in_packet_q;
  assign bus.byte_err      = byte_err_q;
  assign bus.byte_count    = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_byte_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_byte_framer
// Brief    : Directed self-checking bench for rx_byte_framer (three configs).
// Revision : 1.0
// ============================================================================
module tb_rx_byte_framer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic strobe = 1'b0;
  logic sin = 1'b0;
  logic eop = 1'b0;
  logic clr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int bv8_cnt = 0;
  int bv_snap;

  always #5 clk = ~clk;

  rx_byte_framer_if #(.DATA_W(8),  .CNT_W(7)) if8  ();
  rx_byte_framer_if #(.DATA_W(8),  .CNT_W(3)) if3  ();
  rx_byte_framer_if #(.DATA_W(16), .CNT_W(7)) if16 ();

  assign if8.shift_strobe  = strobe;
  assign if8.serial_in     = sin;
  assign if8.eop           = eop;
  assign if8.clear         = clr;
  assign if3.shift_strobe  = strobe;
  assign if3.serial_in     = sin;
  assign if3.eop           = eop;
  assign if3.clear         = clr;
  assign if16.shift_strobe = strobe;
  assign if16.serial_in    = sin;
  assign if16.eop          = eop;
  assign if16.clear        = clr;

  rx_byte_framer #(.DATA_W(8), .CNT_W(7)) dut8 (
    .clk (clk), .n_rst (n_rst), .bus (if8)
  );
  rx_byte_framer #(.DATA_W(8), .CNT_W(3)) dut_sat (
    .clk (clk), .n_rst (n_rst), .bus (if3)
  );
  rx_byte_framer #(.DATA_W(16), .SYNC_PATTERN(16'h8000), .LSB_FIRST(1'b0), .CNT_W(7)) dut16 (
    .clk (clk), .n_rst (n_rst), .bus (if16)
  );

  always @(posedge clk) if (if8.byte_valid) bv8_cnt <= bv8_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    strobe = 1'b1;
    sin    = b;
    tick();
    strobe = 1'b0;
    sin    = 1'b0;
  endtask

  task automatic send_byte8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_word16(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_reset();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] b55;
    b55 = 8'h55;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rx_data",  32'(if8.rx_data),       32'h0);
    check_val("rst_valid",    32'(if8.byte_valid),    32'h0);
    check_val("rst_sync",     32'(if8.sync_detected), 32'h0);
    check_val("rst_inpkt",    32'(if8.in_packet),     32'h0);
    check_val("rst_err",      32'(if8.byte_err),      32'h0);
    check_val("rst_count",    32'(if8.byte_count),    32'h0);
    n_rst = 1'b1;
    tick();

    // SYNC then 0xA5
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check_val("sync_early", 32'(if8.sync_detected), 32'h0);
    send_bit(1'b1);
    check_val("sync_pulse", 32'(if8.sync_detected), 32'h1);
    check_val("sync_inpkt", 32'(if8.in_packet),     32'h1);
    check_val("sync_count", 32'(if8.byte_count),    32'h0);
    send_bit(1'b1);
    check_val("sync_drop",  32'(if8.sync_detected), 32'h0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check_val("a5_early",   32'(if8.byte_valid),    32'h0);
    send_bit(1'b1);
    check_val("a5_valid",   32'(if8.byte_valid),    32'h1);
    check_val("a5_data",    32'(if8.rx_data),       32'ha5);
    check_val("a5_count",   32'(if8.byte_count),    32'h1);
    tick();
    check_val("a5_vdrop",   32'(if8.byte_valid),    32'h0);
    check_val("a5_hold",    32'(if8.rx_data),       32'ha5);

    // SYNC-valued data byte is ordinary data
    send_byte8(8'h80);
    check_val("lk_valid",   32'(if8.byte_valid),    32'h1);
    check_val("lk_data",    32'(if8.rx_data),       32'h80);
    check_val("lk_nosync",  32'(if8.sync_detected), 32'h0);
    check_val("lk_count",   32'(if8.byte_count),    32'h2);

    // Truncated byte at eop
    send_byte8(8'h3c);
    check_val("3c_data",    32'(if8.rx_data),       32'h3c);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bv_snap = bv8_cnt;
    eop = 1'b1;
    tick();
    eop = 1'b0;
    check_val("tr_err",     32'(if8.byte_err),      32'h1);
    check_val("tr_valid",   32'(if8.byte_valid),    32'h0);
    check_val("tr_data",    32'(if8.rx_data),       32'h3c);
    check_val("tr_inpkt",   32'(if8.in_packet),     32'h0);
    check_val("tr_count",   32'(if8.byte_count),    32'h3);
    tick();
    check_val("tr_errdrop", 32'(if8.byte_err),      32'h0);
    check_val("tr_nobv",    32'(bv8_cnt - bv_snap), 32'h0);

    // eop together with the byte-completing strobe
    send_byte8(8'h80);
    check_val("e8_sync",    32'(if8.sync_detected), 32'h1);
    check_val("e8_cnt0",    32'(if8.byte_count),    32'h0);
    for (int i = 0; i < 7; i++) send_bit(b55[i]);
    bv_snap = bv8_cnt;
    strobe = 1'b1; sin = b55[7]; eop = 1'b1;
    tick();
    strobe = 1'b0; sin = 1'b0; eop = 1'b0;
    check_val("e8_valid",   32'(if8.byte_valid),    32'h0);
    check_val("e8_err",     32'(if8.byte_err),      32'h1);
    check_val("e8_inpkt",   32'(if8.in_packet),     32'h0);
    check_val("e8_data",    32'(if8.rx_data),       32'h3c);
    send_byte8(8'h00);
    check_val("e8_hunt",    32'(if8.in_packet),     32'h0);
    check_val("e8_nobv",    32'(bv8_cnt - bv_snap), 32'h0);
    send_byte8(8'h80);
    check_val("e8_resync",  32'(if8.sync_detected), 32'h1);
    send_byte8(8'hc3);
    check_val("e8_newdata", 32'(if8.rx_data),       32'hc3);
    check_val("e8_newcnt",  32'(if8.byte_count),    32'h1);

    // clear wins over a coincident strobe and never flags byte_err
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    strobe = 1'b1; sin = 1'b1; clr = 1'b1;
    tick();
    strobe = 1'b0; sin = 1'b0; clr = 1'b0;
    check_val("clr_err",    32'(if8.byte_err),      32'h0);
    check_val("clr_inpkt",  32'(if8.in_packet),     32'h0);
    check_val("clr_data",   32'(if8.rx_data),       32'hc3);

    // Asynchronous reset mid-byte
    send_byte8(8'h80);
    send_byte8(8'h5a);
    check_val("ar_pre",     32'(if8.rx_data),       32'h5a);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    check_val("ar_data",    32'(if8.rx_data),       32'h0);
    check_val("ar_count",   32'(if8.byte_count),    32'h0);
    check_val("ar_inpkt",   32'(if8.in_packet),     32'h0);
    n_rst = 1'b1;
    tick();
    bv_snap = bv8_cnt;
    send_byte8(8'h00);
    send_byte8(8'h00);
    check_val("ar_hunt",    32'(if8.in_packet),     32'h0);
    check_val("ar_nobv",    32'(bv8_cnt - bv_snap), 32'h0);

    // Saturating count with back-to-back strobes (CNT_W=3)
    pulse_reset();
    send_byte8(8'h80);
    check_val("sat_sync",   32'(if3.sync_detected), 32'h1);
    for (int k = 1; k <= 10; k++) begin
      send_byte8(8'(k * 17));
      check_val("sat_valid", 32'(if3.byte_valid),   32'h1);
      check_val("sat_count", 32'(if3.byte_count),   (k > 7) ? 32'd7 : 32'(k));
    end
    check_val("sat_data",   32'(if3.rx_data),       32'haa);
    tick();
    check_val("sat_vdrop",  32'(if3.byte_valid),    32'h0);

    // 16-bit, MSB-first, SYNC 0x8000
    pulse_reset();
    send_bit(1'b1);
    for (int i = 0; i < 14; i++) send_bit(1'b0);
    check_val("w16_early",  32'(if16.in_packet),     32'h0);
    send_bit(1'b0);
    check_val("w16_sync",   32'(if16.sync_detected), 32'h1);
    send_word16(16'hbeef);
    check_val("w16_valid",  32'(if16.byte_valid),    32'h1);
    check_val("w16_data",   32'(if16.rx_data),       32'hbeef);
    check_val("w16_count",  32'(if16.byte_count),    32'h1);
    send_word16(16'h1234);
    check_val("w16_data2",  32'(if16.rx_data),       32'h1234);
    check_val("w16_count2", 32'(if16.byte_count),    32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
